// File: rtl/ff_rr_sched.sv
// ff_rr_sched: round-robin front end for a shared in-order datapath.
// Handshake: a requester word moves when req_valid[k] and req_ready[k] are
// both high on a rising edge. req_ready is combinational, one-hot at most, and
// only offered while fewer than MAX_OUT results are pending. Results come back
// in issue order and are routed to the requester recorded in the tag FIFO.
module ff_rr_sched #(
    parameter  int SIZE    = 32,
    parameter  int NREQ    = 4,
    parameter  int MAX_OUT = 4,
    localparam int CW      = $clog2(MAX_OUT + 1),
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int PW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 dp_valid_i,
    output logic [SIZE-1:0]      dp_data_i,
    input  logic [SIZE-1:0]      dp_data_o,
    input  logic                 dp_valid_o,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [SIZE-1:0]      rsp_data,
    output logic [CW-1:0]        outstanding,
    output logic                 err
);

    logic [IW-1:0]   r_last;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [IW-1:0]   r_tags [MAX_OUT];
    logic            r_dp_valid;
    logic [SIZE-1:0] r_dp_data;
    logic [NREQ-1:0] r_rsp_valid;
    logic [SIZE-1:0] r_rsp_data;
    logic            r_err;

    logic [IW-1:0]   w_win_idx;
    logic [IW-1:0]   w_probe;
    logic            w_found;
    logic [NREQ-1:0] w_grant;
    logic            w_can_accept;
    logic            w_xfer;
    logic            w_pop;
    logic            w_orphan;
    logic [SIZE-1:0] w_word;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_probe   = '0;
        w_grant   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_probe = IW'((int'(r_last) + i) % NREQ);
            if (!w_found && req_valid[w_probe]) begin
                w_found   = 1'b1;
                w_win_idx = w_probe;
            end
        end
        if (w_found) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end

    // Ready is withheld during reset and whenever the in-flight count is full;
    // a pop in the same cycle does not bypass the full condition.
    assign w_can_accept = reset && (r_count < CW'(MAX_OUT));
    assign req_ready    = w_can_accept ? w_grant : '0;
    assign w_xfer       = |(req_valid & req_ready);
    assign w_word       = req_data[int'(w_win_idx)*SIZE +: SIZE];
    assign w_pop        = dp_valid_o && (r_count != '0);
    assign w_orphan     = dp_valid_o && (r_count == '0);

    // Issue register: one-cycle strobe, data holds the last issued word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dp_valid <= 1'b0;
            r_dp_data  <= '0;
        end else begin
            r_dp_valid <= w_xfer;
            if (w_xfer) begin
                r_dp_data <= w_word;
            end
        end
    end

    // Arbitration pointer moves only on a completed transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= IW'(NREQ - 1);
        end else if (w_xfer) begin
            r_last <= w_win_idx;
        end
    end

    // Tag FIFO pointers and in-flight count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_xfer) begin
                r_wptr <= (r_wptr == PW'(MAX_OUT - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(MAX_OUT - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; emptiness is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_tags[r_wptr] <= w_win_idx;
        end
    end

    // Result routing to the oldest tag, one cycle after the datapath strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_pop) begin
                r_rsp_valid[r_tags[r_rptr]] <= 1'b1;
                r_rsp_data                  <= dp_data_o;
            end
        end
    end

    // Sticky flag for results that arrive with nothing in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_orphan) begin
            r_err <= 1'b1;
        end
    end

    assign dp_valid_i  = r_dp_valid;
    assign dp_data_i   = r_dp_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign outstanding = r_count;
    assign err         = r_err;

endmodule

// File: doc/ff_rr_sched.md
FF_RR_SCHED -- requirements
Module: ff_rr_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SIZE     32  datapath word width
  NREQ     4   number of requesters
  MAX_OUT  4   max issued-but-unanswered transactions, range 1..16
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk          input   1                  single clock; all state on rising edge
  reset        input   1                  asynchronous, active-low reset
  req_valid    input   NREQ               requester k has a word pending
  req_data     input   NREQ*SIZE          requester k word at [k*SIZE +: SIZE]
  req_ready    output  NREQ               one-hot grant/accept to requester k
  dp_valid_i   output  1                  issue strobe to shared datapath
  dp_data_i    output  SIZE               issued word
  dp_data_o    input   SIZE               datapath result
  dp_valid_o   input   1                  datapath result strobe, in issue order
  rsp_valid    output  NREQ               one-hot result strobe to requester k
  rsp_data     output  SIZE               result word, valid with rsp_valid
  outstanding  output  clog2(MAX_OUT+1)   current in-flight count
  err          output  1                  sticky orphan-result flag

Function
REQ-003 Handshake: transfer from requester k occurs in a cycle where req_valid[k] and req_ready[k] are both 1; at most one transfer per cycle.
REQ-004 req_ready is combinational, at most one bit set, set only for the winning requester, and only while outstanding < MAX_OUT.
REQ-005 Arbitration is round-robin: search starts at index (last_granted+1) mod NREQ, wraps through NREQ-1 to 0; first requester with req_valid=1 wins.
REQ-006 last_granted updates only on a completed transfer; no transfer leaves the pointer unchanged.
REQ-007 Issue latency: transfer in cycle T gives dp_valid_i=1 with dp_data_i=that word in cycle T+1, exactly one cycle; dp_valid_i=0 otherwise, dp_data_i holds last issued value.
REQ-008 Each transfer pushes the winner index into an internal tag FIFO of depth MAX_OUT; FIFO order equals issue order.
REQ-009 Return: dp_valid_o=1 in cycle U with FIFO non-empty pops tag t; in U+1 rsp_valid[t]=1 (one-hot) and rsp_data=dp_data_o sampled at U; rsp_valid=0 otherwise.
REQ-010 outstanding +1 on transfer, -1 on pop; transfer and pop in same cycle leave it unchanged; it never exceeds MAX_OUT and never underflows.
REQ-011 Full boundary: outstanding==MAX_OUT forces req_ready=0 even if a pop occurs the same cycle (no bypass); ready returns the cycle after the count drops.
REQ-012 Orphan: dp_valid_o=1 with FIFO empty produces no rsp_valid, no count change, sets err=1; err stays 1 until reset.
REQ-013 A requester holding req_valid across multiple grants is served again only after all other valid requesters have been served once.

Reset
REQ-014 reset=0 asynchronously clears: req_ready (once combinationally re-evaluated) 0, dp_valid_i 0, dp_data_i 0, rsp_valid 0, rsp_data 0, outstanding 0, err 0, tag FIFO empty, last_granted=NREQ-1 (requester 0 highest priority first).
REQ-015 Reset mid-operation discards all in-flight tags; results returned after reset deassertion are orphans per REQ-012.
REQ-016 No transfer is accepted in a cycle where reset=0; first transfer possible in the first rising edge with reset=1.

Verification
REQ-017 All four req_valid=1 held, datapath latency 2, return every issue -> grants 0,1,2,3,0,... one per cycle; rsp_valid order 0,1,2,3 each 3 cycles after its grant cycle +1.
REQ-018 MAX_OUT=4, no dp_valid_o -> exactly 4 transfers, then req_ready=0, outstanding=4; one dp_valid_o -> rsp_valid to first tag, req_ready resumes next cycle.
REQ-019 Only requester 2 valid with data 0xA5A5_0002, datapath echoes -> dp_valid_i one cycle after transfer, rsp_valid=4'b0100, rsp_data=0xA5A5_0002.
REQ-020 Transfer and dp_valid_o same cycle at outstanding=2 -> outstanding stays 2, one rsp_valid next cycle.
REQ-021 dp_valid_o with FIFO empty -> err=1, rsp_valid stays 0, outstanding stays 0; err holds until reset.
REQ-022 reset pulsed with outstanding=3 -> all outputs 0 immediately; later dp_valid_o sets err; requester 0 wins first post-reset arbitration.
